// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor with sign-magnitude result; one digit per clock.
// Latency: add and a<=b subtract finish with done in cycle N+1; a>b subtract in 2N+1
//          (N+1+k with BCD_FIX_EARLY_EXIT_EN, k = digits touched by the +1 fix pass).
// Backpressure: none; start is honoured only while idle, and is ignored while busy.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op       request (0 = add, 1 = a - b), sampled together with a, b when idle
//   a, b            N-digit BCD operands, digit 0 in bits [3:0]
//   busy            operation in progress (low again in the done cycle)
//   done            one-cycle pulse; o/co/neg valid from this cycle and held to the next done
//   o, co, neg      magnitude, decimal carry out (add only), negative flag (subtract only)
//
// Optional macro: BCD_FIX_EARLY_EXIT_EN stops the +1 fix pass at the first digit
// that absorbs the carry.
module bcd_serial_addsub #(
  parameter int N = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [N*4-1:0] a,
  input  logic [N*4-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [N*4-1:0] o,
  output logic           co,
  output logic           neg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, FIX} state_t;

  state_t         state, state_nxt;
  logic [N*4-1:0] a_r, b_r, res, res_nxt, b_in, res_inv;
  logic           op_r, carry, carry_nxt;
  logic [IW-1:0]  idx;
  logic [IW+1:0]  boff;
  logic [3:0]     da, db, dr, dnew;
  logic [4:0]     s;
  logic           last, fix_end, finish;

  // Nines' complement of one digit; the non-BCD codes 10..15 fold onto 9..4.
  function automatic logic [3:0] nines(input logic [3:0] d);
    nines = (d <= 4'd9) ? (4'd9 - d) : (4'd3 - d);
  endfunction

  function automatic logic [N*4-1:0] nines_vec(input logic [N*4-1:0] v);
    nines_vec = '0;
    for (int i = 0; i < N; i++) begin
      nines_vec[i*4 +: 4] = nines(v[i*4 +: 4]);
    end
  endfunction

  assign b_in    = op ? nines_vec(b) : b;
  assign boff    = {idx, 2'b00};
  assign last    = (idx == IW'(N - 1));
  assign busy    = (state != IDLE);
  assign res_inv = nines_vec(res_nxt);

  // Per-digit datapath shared by ADD and FIX, addressed by idx.
  always_comb begin
    da        = a_r[boff +: 4];
    db        = b_r[boff +: 4];
    dr        = res[boff +: 4];
    s         = {1'b0, da} + {1'b0, db} + {4'b0, carry};
    dnew      = dr;
    carry_nxt = carry;
    res_nxt   = res;
    if (state == ADD) begin
      if (s > 5'd9) begin
        dnew      = s[3:0] + 4'd6;
        carry_nxt = 1'b1;
      end else begin
        dnew      = s[3:0];
        carry_nxt = 1'b0;
      end
    end else if (state == FIX) begin
      // Once the carry is absorbed the remaining digits pass through.
      if (!carry) begin
        dnew      = dr;
        carry_nxt = 1'b0;
      end else if (dr == 4'd9) begin
        dnew      = 4'd0;
        carry_nxt = 1'b1;
      end else begin
        dnew      = dr + 4'd1;
        carry_nxt = 1'b0;
      end
    end
    res_nxt[boff +: 4] = dnew;
  end

`ifdef BCD_FIX_EARLY_EXIT_EN
  assign fix_end = last || !carry_nxt;
`else
  assign fix_end = last;
`endif

  // Next state and the completion strobe.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        if (last) begin
          if (op_r && carry_nxt) begin
            state_nxt = FIX;
          end else begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end
        end
      end
      FIX: begin
        if (fix_end) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      op_r  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      done  <= 1'b0;
      o     <= '0;
      co    <= 1'b0;
      neg   <= 1'b0;
    end else begin
      done <= finish;
      if (state == IDLE) begin
        if (start) begin
          a_r   <= a;
          b_r   <= b_in;
          op_r  <= op;
          idx   <= '0;
          carry <= 1'b0;
        end
      end else begin
        res   <= res_nxt;
        carry <= carry_nxt;
        idx   <= (last || state_nxt != state) ? '0 : idx + 1'b1;
      end
      if (finish) begin
        if (state == ADD && op_r) begin
          // No end-around carry: a <= b, the magnitude is the complemented sum.
          o   <= res_inv;
          neg <= |res_inv;
          co  <= 1'b0;
        end else if (state == ADD) begin
          o   <= res_nxt;
          neg <= 1'b0;
          co  <= carry_nxt;
        end else begin
          o   <= res_nxt;
          neg <= 1'b0;
          co  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub at N = 4: directed cases plus random add/subtract
// checked against an integer-arithmetic model of result, flags and latency.
// No backpressure to model; start is driven only in idle or done cycles except in the ignore test.
module tb_bcd_serial_addsub;

  localparam int NT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            op = 1'b0;
  logic [NT*4-1:0] a = '0;
  logic [NT*4-1:0] b = '0;
  logic            busy, done, co, neg;
  logic [NT*4-1:0] o;

  int total = 0;
  int bad   = 0;

  bcd_serial_addsub #(.N(NT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .o(o), .co(co), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NT*4-1:0] to_bcd(input int v);
    int t;
    t = v;
    to_bcd = '0;
    for (int i = 0; i < NT; i++) begin
      to_bcd[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
  endfunction

  // Issue one operation and wait for its done pulse, checking against the model.
  task automatic run_op(input string tag, input logic opv, input int av, input int bv);
    int cyc, elat, s, d, k, lim;
    bit seen, busy_ok;
    logic [NT*4-1:0] eo;
    logic eco, eneg;
    lim = 10000;
    if (!opv) begin
      s    = av + bv;
      eo   = to_bcd(s % lim);
      eco  = (s >= lim);
      eneg = 1'b0;
      elat = NT + 1;
    end else begin
      eo   = to_bcd((av >= bv) ? av - bv : bv - av);
      eco  = 1'b0;
      eneg = (av < bv);
      elat = NT + 1;
      if (av > bv) begin
`ifdef BCD_FIX_EARLY_EXIT_EN
        // The fix pass adds 1 to a-b-1; it ripples through trailing nines.
        d = av - bv - 1;
        k = 1;
        while ((d % 10) == 9 && k < NT) begin
          k++;
          d = d / 10;
        end
        elat = NT + 1 + k;
`else
        k = NT;
        elat = 2*NT + 1;
`endif
      end
    end
    @(negedge clk);
    op = opv; a = to_bcd(av); b = to_bcd(bv); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 0; busy_ok = 1;
    while (!seen && cyc <= 3*NT + 4) begin
      if (done) seen = 1;
      else begin
        if (!busy) busy_ok = 0;
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_lat"}, 32'(cyc), 32'(elat));
      chk({tag, "_o"},   32'(o),   32'(eo));
      chk({tag, "_co"},  32'(co),  32'(eco));
      chk({tag, "_neg"}, 32'(neg), 32'(eneg));
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    end
    chk({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int cyc, ndone, av, bv;
    bit opv;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_o",    32'(o),    32'd0);
    chk("rst_co",   32'(co),   32'd0);
    chk("rst_neg",  32'(neg),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_1234_8766", 1'b0, 1234, 8766);
    run_op("sub_5000_1234", 1'b1, 5000, 1234);
    run_op("sub_1234_5000", 1'b1, 1234, 5000);
    run_op("sub_0042_0042", 1'b1, 42, 42);
    run_op("sub_1000_0000", 1'b1, 1000, 0);
    run_op("sub_0000_9999", 1'b1, 0, 9999);
    run_op("add_9999_9999", 1'b0, 9999, 9999);

    // start held high for the whole add: later requests must be ignored.
    @(negedge clk);
    op = 1'b0; a = to_bcd(1111); b = to_bcd(2222); start = 1'b1;
    @(negedge clk);
    a = to_bcd(9999); b = to_bcd(9999); op = 1'b1;
    cyc = 1; ndone = 0;
    while (ndone == 0 && cyc <= 3*NT) begin
      if (done) ndone++;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("hold_start_ndone", 32'(ndone), 32'd1);
    chk("hold_start_lat",   32'(cyc),   32'(NT + 1));
    chk("hold_start_o",     32'(o),     32'(to_bcd(3333)));
    // Request in the done cycle is accepted back to back.
    op = 1'b0; a = to_bcd(1); b = to_bcd(1);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; ndone = 0;
    while (ndone == 0 && cyc <= 3*NT) begin
      if (done) ndone++;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("b2b_ndone", 32'(ndone), 32'd1);
    chk("b2b_lat",   32'(cyc),   32'(NT + 1));
    chk("b2b_o",     32'(o),     32'(to_bcd(2)));

    // Reset in cycle 3 of a subtract aborts without a done pulse.
    @(negedge clk);
    op = 1'b1; a = to_bcd(5000); b = to_bcd(1234); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_o",    32'(o),    32'd0);
    ndone = 0;
    for (int i = 0; i < 3*NT; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done) ndone++;
    end
    chk("abort_ndone", 32'(ndone), 32'd0);
    run_op("add_0009_0001", 1'b0, 9, 1);

    for (int i = 0; i < 40; i++) begin
      av  = int'($urandom_range(9999, 0));
      bv  = (i % 8 == 0) ? av : int'($urandom_range(9999, 0));
      opv = 1'($urandom_range(1, 0));
      run_op($sformatf("rnd%0d", i), opv, av, bv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
Digit-serial BCD adder/subtractor for the decimal FPU datapath. It is the low-area, multi-cycle counterpart to the parallel BCD subtract path and also performs addition. It processes one BCD digit per clock and returns sign-magnitude results. Subtraction uses nines'-complement addition with end-around-carry correction.

Parameters:
N, 25, number of BCD digits per operand and result.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only while the block is idle
op  input  1  0 = add, 1 = subtract (a - b); sampled on accept
a  input  N*4  BCD operand, digit 0 in bits [3:0]; sampled on accept
b  input  N*4  BCD operand; sampled on accept
busy  output  1  operation in progress
done  output  1  one-cycle pulse; o, co and neg are valid from this cycle
o  output  N*4  result: sum, or |a - b| for subtract
co  output  1  add: decimal carry out of digit N-1; subtract: 0
neg  output  1  subtract only: 1 when a < b; 0 for add and for a zero result

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - busy, done, co and neg are 0; o is all zeros.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, ADD, FIX.
- Accept: start = 1 while in IDLE is cycle 0.
  - Latch a and op. Latch b when op = 0, or its digit-wise nines' complement when op = 1 (input digits 10..15 map to 9..4).
  - Clear the digit index and the carry; go to ADD.
  - start while busy = 1 is ignored and has no side effects.
- ADD: cycle k (k = 1..N) processes digit k-1.
  - s = a_d + b_d + carry. If s > 9, the digit is s + 6 truncated to 4 bits and carry = 1; otherwise the digit is s and carry = 0.
  - Each result digit is written into an internal result register.
- End of ADD, after cycle N, with final carry c:
  - op = 0: o = sum, co = c, neg = 0. done = 1 in cycle N+1; return to IDLE.
  - op = 1 and c = 0: o = nines' complement of sum, neg = (o != 0), co = 0. done in cycle N+1; IDLE.
  - op = 1 and c = 1: go to FIX and add 1 to the sum, digit-serially, with carry-in 1.
- FIX: one digit per cycle, starting at digit 0.
  - A digit of 9 plus the carry becomes 0 and the carry stays 1; otherwise the digit increments and the carry becomes 0.
  - Runs all N digits: cycles N+1..2N.
  - Then o = result, neg = 0, co = 0; done in cycle 2N+1; IDLE.
- busy: 1 from cycle 1 through the cycle before done; 0 in the done cycle.
- done cycle: the block is in IDLE, so start in that same cycle is accepted (back-to-back operations).
- Holding: o, co and neg hold their values until the next done. They are not cleared on accept.
- Non-BCD inputs (digits 10..15 in a, or in b for add): o is unspecified, but the FSM latency and handshake are unchanged.
- Width: the internal carry is 1 bit. No digit beyond N is stored; the add overflow is reported only on co.

Optional Feature:
BCD_FIX_EARLY_EXIT_EN
- Defined: FIX terminates in the cycle that processes the first digit producing carry = 0. With k digits processed, done is in cycle N+1+k (1 <= k <= N). The remaining digits are passed through unchanged.
- Undefined: FIX always runs N cycles, giving a fixed subtract-with-carry latency of 2N+1. Results are identical either way.

Test Plan (N = 4, values shown as BCD digit strings):
1. Add 1234 + 8766 -> o = 0000, co = 1, neg = 0. done in cycle 5; busy high in cycles 1-4.
2. Subtract 5000 - 1234 -> o = 3766, neg = 0. done in cycle 9; with BCD_FIX_EARLY_EXIT_EN, done in cycle 6.
3. Subtract 1234 - 5000 -> o = 3766, neg = 1, co = 0. done in cycle 5, with no FIX pass.
4. Subtract 0042 - 0042 -> o = 0000, neg = 0. Subtract 1000 - 0000 -> o = 1000, neg = 0. For the second, with the macro defined, done is in cycle 9 (k = 4).
5. Pulse start every cycle during an add of 1111 + 2222 -> exactly one done, o = 3333. Then assert start in the done cycle with 0001 + 0001 -> accepted, o = 0002 five cycles later.
6. Assert rst_n = 0 in cycle 3 of a subtract -> busy = 0, o = 0000, no done. After release, an add of 0009 + 0001 -> o = 0010, co = 0.
